// File: rtl/psram_qpi_master_if.sv
// Request/response bus between a bus-side client and the PSRAM QPI master.
// The client drives requests through the master modport.
// The QPI master consumes them through the slave modport.
interface psram_qpi_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/psram_qpi_master.sv
// QPI master for the on-board PSRAM.
// Each accepted request becomes one chip-select frame made of these phases:
//   1. command, sent serially on lane 0
//   2. 24-bit address, sent in nibbles
//   3. for reads, dummy cycles followed by 8 read nibbles
//   4. for writes, 2 nibbles per byte
// sck runs at clock/2. Outputs change on sck falling edges and read data is sampled on rising edges.
module psram_qpi_master #(
    parameter logic [7:0] CMD_READ  = 8'hEB,
    parameter logic [7:0] CMD_WRITE = 8'h38,
    parameter int         WAIT_SCK  = 6
) (
    input  logic                     clock,
    input  logic                     rst_n,
    psram_qpi_master_if.slave        bus,
    output logic                     psram_sck,
    output logic                     psram_ce_n,
    output logic [3:0]               psram_dout,
    output logic [3:0]               psram_doe,
    input  logic [3:0]               psram_din
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WAIT, S_READ, S_WDATA, S_DONE
    } state_t;

    state_t      r_state, w_stateNext;
    logic [3:0]  r_cnt, w_cntNext, w_phaseLen;
    logic        r_sck, r_ceN, r_rspValid, r_we;
    logic [3:0]  r_dout, r_doe, w_doutNext, w_doeNext;
    logic [23:0] r_addr;
    logic [31:0] r_wdata, r_rdBuf, r_rspRdata;
    logic [3:0]  r_wrLen;
    logic        w_accept, w_inFrame, w_fall, w_lastFall;
    logic [7:0]  w_cmd;
    logic [2:0]  w_rdNib;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
    assign w_inFrame  = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_WAIT) ||
                        (r_state == S_READ) || (r_state == S_WDATA);
    assign w_fall     = w_inFrame && r_sck;
    assign w_lastFall = w_fall && (r_cnt == w_phaseLen - 4'd1);
    // The command opcode is sent before r_we is loaded, so it is taken from the live request while idle.
    assign w_cmd      = (r_state == S_IDLE) ? (bus.req_we ? CMD_WRITE : CMD_READ)
                                            : (r_we ? CMD_WRITE : CMD_READ);
    // Read nibbles arrive on READ rising edges 2..9, so counts 1..8 map to nibbles 0..7.
    assign w_rdNib    = r_cnt[2:0] - 3'd1;

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_rdata = r_rspRdata;
    assign psram_sck     = r_sck;
    assign psram_ce_n    = r_ceN;
    assign psram_dout    = r_dout;
    assign psram_doe     = r_doe;

    // State register and sck-cycle counter within the current phase
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Phase length in sck cycles, next state and next phase count
    always_comb begin
        w_phaseLen  = 4'd1;
        w_stateNext = r_state;
        case (r_state)
            S_CMD:   w_phaseLen = 4'd8;
            S_ADDR:  w_phaseLen = 4'd6;
            S_WAIT:  w_phaseLen = 4'(WAIT_SCK);
            S_READ:  w_phaseLen = 4'd9;
            S_WDATA: w_phaseLen = r_wrLen;
            default: w_phaseLen = 4'd1;
        endcase
        case (r_state)
            S_IDLE:  if (bus.req_valid) w_stateNext = S_CMD;
            S_CMD:   if (w_lastFall) w_stateNext = S_ADDR;
            S_ADDR:  if (w_lastFall) w_stateNext = r_we ? S_WDATA : S_WAIT;
            S_WAIT:  if (w_lastFall) w_stateNext = S_READ;
            S_READ:  if (w_lastFall) w_stateNext = S_DONE;
            S_WDATA: if (w_lastFall) w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
        if (w_stateNext != r_state) begin
            w_cntNext = 4'd0;
        end else if (w_fall) begin
            w_cntNext = r_cnt + 4'd1;
        end else begin
            w_cntNext = r_cnt;
        end
    end

    // Pin values for the sck cycle that begins at this edge
    always_comb begin
        w_doutNext = 4'h0;
        w_doeNext  = 4'h0;
        case (w_stateNext)
            S_CMD: begin
                w_doutNext = {3'b000, w_cmd[3'd7 - w_cntNext[2:0]]};
                w_doeNext  = 4'hF;
            end
            S_ADDR: begin
                w_doutNext = r_addr[{3'd5 - w_cntNext[2:0], 2'b00} +: 4];
                w_doeNext  = 4'hF;
            end
            S_WDATA: begin
                w_doutNext = r_wdata[{w_cntNext[2:1], ~w_cntNext[0], 2'b00} +: 4];
                w_doeNext  = 4'hF;
            end
            default: begin
                w_doutNext = 4'h0;
                w_doeNext  = 4'h0;
            end
        endcase
    end

    // sck generation, pin updates on falling edges, request capture and read assembly
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sck      <= 1'b0;
            r_ceN      <= 1'b1;
            r_dout     <= 4'h0;
            r_doe      <= 4'h0;
            r_rspValid <= 1'b0;
            r_rspRdata <= 32'h0;
            r_rdBuf    <= 32'h0;
            r_we       <= 1'b0;
            r_addr     <= 24'h0;
            r_wdata    <= 32'h0;
            r_wrLen    <= 4'd0;
        end else begin
            r_ceN      <= (w_stateNext == S_IDLE) || (w_stateNext == S_DONE);
            r_rspValid <= (r_state == S_DONE);
            if (w_inFrame) begin
                r_sck <= ~r_sck;
            end
            if (w_accept || w_fall) begin
                r_dout <= w_doutNext;
                r_doe  <= w_doeNext;
            end
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                case (bus.req_size)
                    2'd0:    r_wrLen <= 4'd2;
                    2'd1:    r_wrLen <= 4'd4;
                    default: r_wrLen <= 4'd8;
                endcase
            end
            if ((r_state == S_READ) && !r_sck && (r_cnt != 4'd0)) begin
                r_rdBuf[{w_rdNib[2:1], ~w_rdNib[0], 2'b00} +: 4] <= psram_din;
            end
            if ((r_state == S_DONE) && !r_we) begin
                r_rspRdata <= r_rdBuf;
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_master.sv
// Testbench for psram_qpi_master.
// A behavioural PSRAM device decodes the QPI frames.
// A scoreboard queues the expected response for each request and checks data and latency when rsp_valid pulses.
module tb_psram_qpi_master;
    localparam int WAIT_SCK = 6;

    typedef struct packed {
        logic        we;
        logic [31:0] rdata;
        logic [31:0] latency;
    } expT;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       psram_sck, psram_ce_n;
    logic [3:0] psram_dout, psram_doe, psram_din;

    psram_qpi_master_if busIf();

    psram_qpi_master #(
        .CMD_READ (8'hEB),
        .CMD_WRITE(8'h38),
        .WAIT_SCK (WAIT_SCK)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .bus       (busIf),
        .psram_sck (psram_sck),
        .psram_ce_n(psram_ce_n),
        .psram_dout(psram_dout),
        .psram_doe (psram_doe),
        .psram_din (psram_din)
    );

    always #5 clock = ~clock;

    int         compareCount  = 0;
    int         mismatchCount = 0;
    int         cycleCnt      = 0;
    expT        expQ[$];
    int         acceptQ[$];
    logic [7:0] refMem [0:4095];

    // Checks one observed value against its expected value and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Counts clock edges so that latencies can be measured from the accept edge
    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // PSRAM device model: decodes the command and address, stores write nibbles and returns read nibbles
    logic [7:0] devMem [0:4095];
    int         riseCnt  = 0;
    logic [7:0] devCmd   = 8'h0;
    logic [23:0] devAddr = 24'h0;
    logic [3:0] devDrive = 4'h0;
    logic [3:0] wrNibQ[$];
    assign psram_din = devDrive;

    always @(posedge psram_ce_n) begin
        riseCnt  = 0;
        devDrive = 4'h0;
    end

    always @(posedge psram_sck) begin : devModel
        int         k;
        logic [11:0] a;
        if (!psram_ce_n) begin
            if (riseCnt < 8) begin
                devCmd = {devCmd[6:0], psram_dout[0]};
            end else if (riseCnt < 14) begin
                devAddr = {devAddr[19:0], psram_dout};
            end else if (devCmd == 8'h38) begin
                k = riseCnt - 14;
                a = devAddr[11:0] + 12'(k / 2);
                if (k % 2 == 0) devMem[a][7:4] = psram_dout;
                else            devMem[a][3:0] = psram_dout;
                wrNibQ.push_back(psram_dout);
            end else if (riseCnt >= 14 + WAIT_SCK && riseCnt < 22 + WAIT_SCK) begin
                k = riseCnt - (14 + WAIT_SCK);
                a = devAddr[11:0] + 12'(k / 2);
                devDrive = (k % 2 == 0) ? devMem[a][7:4] : devMem[a][3:0];
            end
            riseCnt++;
        end
    end

    // Monitor: records accepts, checks responses against the scoreboard, and tracks doe, sck and ce_n gaps
    int   curAccept     = -1;
    logic curWe         = 1'b0;
    int   doeErr        = 0;
    int   sckToggles    = 0;
    logic lastSck       = 1'b0;
    int   ceHighRun     = 0;
    int   lastGap       = -1;
    int   rspCount      = 0;
    logic rspWithAccept = 1'b0;

    always @(negedge clock) begin : monitor
        expT  e;
        int   acc;
        int   rel;
        logic [3:0] doeExp;
        if (rst_n) begin
            rel = cycleCnt - curAccept;
            if (curAccept >= 0 && !curWe && rel >= 0 && rel <= 58) begin
                doeExp = (rel < 28) ? 4'hF : 4'h0;
                if (psram_doe !== doeExp) doeErr++;
            end
            if (busIf.req_valid && busIf.req_ready) begin
                acceptQ.push_back(cycleCnt + 1);
                curAccept = cycleCnt + 1;
                curWe     = busIf.req_we;
            end
            if (busIf.rsp_valid) begin
                rspCount++;
                if (busIf.req_valid && busIf.req_ready) rspWithAccept = 1'b1;
                if (expQ.size() == 0 || acceptQ.size() == 0) begin
                    checkOutput("spuriousRsp", 32'd1, 32'd0);
                end else begin
                    e   = expQ.pop_front();
                    acc = acceptQ.pop_front();
                    if (e.we) begin
                        checkOutput("wrLatency", cycleCnt - acc, e.latency);
                    end else begin
                        checkOutput("rdLatency", cycleCnt - acc, e.latency);
                        checkOutput("rdData", busIf.rsp_rdata, e.rdata);
                    end
                end
            end
            if (psram_sck !== lastSck) sckToggles++;
            lastSck = psram_sck;
            if (psram_ce_n) begin
                ceHighRun++;
            end else begin
                if (ceHighRun > 0) lastGap = ceHighRun;
                ceHighRun = 0;
            end
        end
    end

    // Queues the expected response, then presents one request and waits, bounded, for its accept
    task automatic applyStimulus(input logic we, input logic [23:0] addr, input logic [1:0] size,
                                 input logic [31:0] wdata, input logic holdValid);
        expT e;
        int  bytes;
        int  waited;
        bytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e.we  = we;
        e.rdata = 32'h0;
        if (we) begin
            e.latency = 2 * (14 + 2 * bytes) + 1;
            for (int i = 0; i < bytes; i++) refMem[addr[11:0] + 12'(i)] = wdata[8 * i +: 8];
        end else begin
            e.latency = 2 * (8 + 6 + WAIT_SCK + 9) + 1;
            for (int i = 0; i < 4; i++) e.rdata[8 * i +: 8] = refMem[addr[11:0] + 12'(i)];
        end
        expQ.push_back(e);
        busIf.req_we    = we;
        busIf.req_addr  = addr;
        busIf.req_size  = size;
        busIf.req_wdata = wdata;
        busIf.req_valid = 1'b1;
        waited = 0;
        while (!busIf.req_ready && waited < 200) begin
            @(posedge clock); #1;
            waited++;
        end
        if (waited >= 200) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            void'(expQ.pop_back());
        end
        @(posedge clock); #1;
        if (!holdValid) begin
            busIf.req_valid = 1'b0;
            busIf.req_wdata = 32'h0;
            busIf.req_addr  = 24'hFFFFFF;
        end
    endtask

    // Waits, bounded, until every queued response has been checked
    task automatic waitIdle();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 400) begin
            @(posedge clock); #1;
            n++;
        end
        if (expQ.size() != 0) begin
            checkOutput("rspTimeout", expQ.size(), 32'd0);
            expQ.delete();
            acceptQ.delete();
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] nibWord;
        int          t0;
        int          rspBefore;
        for (int i = 0; i < 4096; i++) begin
            refMem[i] = 8'h00;
            devMem[i] = 8'h00;
        end
        busIf.req_valid = 1'b0;
        busIf.req_we    = 1'b0;
        busIf.req_addr  = 24'h0;
        busIf.req_size  = 2'd0;
        busIf.req_wdata = 32'h0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstCeN", psram_ce_n, 32'd1);
        checkOutput("rstSck", psram_sck, 32'd0);
        checkOutput("rstDoe", psram_doe, 32'd0);
        checkOutput("rstDout", psram_dout, 32'd0);
        checkOutput("rstReady", busIf.req_ready, 32'd1);
        checkOutput("rstRspValid", busIf.rsp_valid, 32'd0);
        checkOutput("rstRdata", busIf.rsp_rdata, 32'd0);
        rst_n = 1'b1;
        t0 = sckToggles;
        repeat (10) @(posedge clock);
        #1;
        checkOutput("idleSckToggles", sckToggles - t0, 32'd0);

        // Word write: command, address and data nibbles as seen by the device
        wrNibQ.delete();
        applyStimulus(1'b1, 24'h000100, 2'd2, 32'hDEADBEEF, 1'b0);
        waitIdle();
        checkOutput("wrCmd", devCmd, 32'h38);
        checkOutput("wrAddr", devAddr, 32'h000100);
        checkOutput("wrNibCount", wrNibQ.size(), 32'd8);
        nibWord = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (i < wrNibQ.size()) nibWord = {nibWord[27:0], wrNibQ[i]};
        end
        checkOutput("wrNibbles", nibWord, 32'hEFBEADDE);

        // Read back with doe checked over the turnaround
        doeErr = 0;
        applyStimulus(1'b0, 24'h000100, 2'd0, 32'h0, 1'b0);
        waitIdle();
        checkOutput("rdCmd", devCmd, 32'hEB);
        checkOutput("rdDoeProfile", doeErr, 32'd0);

        // Byte write into the middle of the word, then read it back
        applyStimulus(1'b1, 24'h000101, 2'd0, 32'h0000005A, 1'b0);
        applyStimulus(1'b0, 24'h000100, 2'd0, 32'h0, 1'b0);
        waitIdle();

        // Half write at a fresh address, then read it back
        applyStimulus(1'b1, 24'h000200, 2'd1, 32'hFFFF1234, 1'b0);
        applyStimulus(1'b0, 24'h000200, 2'd3, 32'h0, 1'b0);
        waitIdle();

        // Back-to-back requests with req_valid held high
        rspWithAccept = 1'b0;
        applyStimulus(1'b0, 24'h000100, 2'd0, 32'h0, 1'b1);
        applyStimulus(1'b1, 24'h000300, 2'd3, 32'hCAFEF00D, 1'b0);
        waitIdle();
        checkOutput("b2bAcceptAtRsp", rspWithAccept, 32'd1);
        checkOutput("b2bCeGapAtLeast2", (lastGap >= 2) ? 32'd1 : 32'd0, 32'd1);
        applyStimulus(1'b0, 24'h000300, 2'd0, 32'h0, 1'b0);
        waitIdle();

        // Reset in the middle of a read frame
        applyStimulus(1'b0, 24'h000100, 2'd0, 32'h0, 1'b0);
        repeat (29) @(posedge clock);
        #1;
        checkOutput("preAbortCeN", psram_ce_n, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abortCeN", psram_ce_n, 32'd1);
        checkOutput("abortDoe", psram_doe, 32'd0);
        checkOutput("abortSck", psram_sck, 32'd0);
        expQ.delete();
        acceptQ.delete();
        curAccept = -1;
        rspBefore = rspCount;
        repeat (3) @(posedge clock);
        #1;
        rst_n = 1'b1;
        repeat (80) @(posedge clock);
        #1;
        checkOutput("abortNoRsp", rspCount - rspBefore, 32'd0);
        applyStimulus(1'b0, 24'h000100, 2'd0, 32'h0, 1'b0);
        waitIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/psram_qpi_master.md
# psram_qpi_master

Bus-side QPI master that drives the on-board PSRAM device model.
- Accepts single read/write requests on a valid/ready port and serialises each one into one chip-select frame: command, address, wait and data phases.
- Reads return a 32-bit word. Writes store 1, 2 or 4 bytes.
- Sits directly upstream of the PSRAM device, whose `sck`/`ce_n`/`dio` it drives; the top level merges `psram_dout`/`psram_doe`/`psram_din` into the `dio` inout.

## Interface
Parameters:
- CMD_READ, 8'hEB, quad read command.
- CMD_WRITE, 8'h38, quad write command.
- WAIT_SCK, 6, dummy sck cycles between address and read data.

Ports:
- clock  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid & ready; high only in IDLE.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  24  byte address, sent as-is with no alignment.
- req_size  in  2  write size: 0 = byte, 1 = half, 2/3 = word. Ignored for reads.
- req_wdata  in  32  write data; byte 0 (bits [7:0]) is sent first.
- rsp_valid  out  1  one-cycle completion pulse, reads and writes. No backpressure.
- rsp_rdata  out  32  read data, valid with rsp_valid. Holds its last value otherwise.
- psram_sck  out  1  serial clock, clock/2.
- psram_ce_n  out  1  chip select, active low.
- psram_dout  out  4  data to device.
- psram_doe  out  4  output enable per lane.
- psram_din  in  4  data from device.

## Operation
- FSM states: IDLE → CMD → ADDR → (WAIT → READ | WDATA) → DONE → IDLE.
- CMD: 8 sck cycles. Command bits go MSB first on dout[0]; dout[3:1] = 0; doe = 4'b1111.
- ADDR: 6 sck cycles. Address nibbles go MSB first on dout[3:0]; doe = 4'b1111.
- WAIT: WAIT_SCK sck cycles; doe = 0.
- READ: 9 sck cycles; doe = 0.
  - The device drives a nibble after each of its rising edges, so the master samples psram_din on read rising edges 2..9.
  - Nibble order: [7:4], [3:0], [15:12], [11:8], [23:20], [19:16], [31:28], [27:24].
- WDATA: 2 × bytes sck cycles; doe = 4'b1111. Each byte goes high nibble first, byte 0 first.
  - Byte count: 1, 2 or 4 per req_size; size 3 is treated as word.
- DONE: ce_n returns high and doe = 0. The next cycle asserts rsp_valid and re-enters IDLE.
- Request fields are captured on accept. Inputs changing afterwards have no effect.

## Timing
- Cycle numbering: E0 is the accept edge; Ek is the k-th clock edge after it.
- Frame start: after E0, ce_n = 0, sck = 0, and dout carries the first command bit.
- sck edges: sck rises at odd edges E(2k−1) and falls at even edges E(2k). dout changes only on falling edges, and din is sampled only on rising edges.
- Frame length N sck cycles:
  - read: N = 8 + 6 + WAIT_SCK + 9 = 29.
  - write: N = 14 + 2 × bytes, giving 16, 18 or 22.
- Frame end: ce_n rises at E(2N) (sck falls on the same edge), rsp_valid pulses at E(2N+1), and req_ready is high from E(2N+1).
- Reads: ce_n high E58, rsp_valid E59.
- Word write: rsp_valid E45. Half write: E37. Byte write: E33.
- Turnaround: earliest next accept is E(2N+1), with ce_n low again after it. ce_n is high for at least 2 clocks between frames.
- Reset values: ce_n = 1, sck = 0, dout = 0, doe = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, FSM = IDLE.
- Reset mid-frame: outputs return to reset values immediately (asynchronously). The aborted frame produces no rsp_valid, and the next request runs normally.

## Test plan
- Reset: hold rst_n = 0 → ce_n = 1, sck = 0, doe = 0, req_ready = 1, rsp_valid = 0. Release and idle 10 cycles → no sck toggles.
- Word write: addr 0x000100, wdata 0xDEADBEEF, size 2.
  - dout[0] command bits 0,0,1,1,1,0,0,0.
  - Address nibbles 0,0,0,1,0,0.
  - Data nibbles E,F,B,E,A,D,D,E.
  - rsp_valid at E45.
- Read back addr 0x000100 → doe = 0 from the first WAIT cycle through ce_n high; rsp_valid at E59 with rsp_rdata = 0xDEADBEEF.
- Byte write addr 0x000101, wdata 0x0000005A, size 0 → rsp_valid at E33. A subsequent read of 0x000100 returns 0xDEAD5AEF.
- Back-to-back: req_valid held high with read then write.
  - Second accept occurs exactly at the first rsp_valid edge.
  - ce_n high ≥ 2 clocks between frames; both responses correct.
- Reset at E30 of a read → ce_n = 1 and doe = 0 immediately, no rsp_valid. A following read of 0x000100 returns 0xDEAD5AEF.
